// File: rtl/fwd_scoreboard.sv
// Operand forwarding, per-register latency scoreboard and in-order issue gate
// feeding the exe0 pipeline register for an ISSUE-wide front end.
module fwd_scoreboard #(
    parameter int ISSUE  = 2,
    parameter int NSRC   = 3,
    parameter int NSTAGE = 2,
    parameter int DW     = 32,
    parameter int MAXLAT = 4,
    localparam int LW    = $clog2(MAXLAT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [ISSUE-1:0]               id_valid,
    input  logic [ISSUE*NSRC*5-1:0]        id_src,
    input  logic [ISSUE*NSRC*DW-1:0]       id_src_rf,
    input  logic [ISSUE*5-1:0]             id_rd,
    input  logic [ISSUE-1:0]               id_we,
    input  logic [ISSUE*LW-1:0]            id_lat,
    input  logic [NSTAGE*ISSUE-1:0]        byp_we,
    input  logic [NSTAGE*ISSUE*5-1:0]      byp_rd,
    input  logic [NSTAGE*ISSUE*DW-1:0]     byp_data,
    output logic [ISSUE-1:0]               id_accept,
    output logic [ISSUE-1:0]               ex_valid,
    output logic [ISSUE*NSRC*DW-1:0]       ex_src,
    output logic [ISSUE*5-1:0]             ex_rd,
    output logic [ISSUE-1:0]               ex_we,
    output logic [31:0]                    stall_cnt
);

    logic [LW-1:0]            cnt_q [32];
    logic [LW-1:0]            cnt_d [32];
    logic [ISSUE-1:0]         hazard;
    logic [ISSUE-1:0]         accept;
    logic [ISSUE*NSRC*DW-1:0] res_src;
    logic [ISSUE-1:0]         ex_valid_q;
    logic [ISSUE-1:0]         ex_we_q;
    logic [ISSUE*NSRC*DW-1:0] ex_src_q;
    logic [ISSUE*5-1:0]       ex_rd_q;
    logic [31:0]              stall_q;
    logic [31:0]              stall_d;

    // Slots are scanned from lowest to highest priority so the youngest
    // producer (stage 0, highest lane) is the last one written.
    always_comb begin : resolve
        logic [4:0]    src;
        logic [DW-1:0] sel;
        src     = '0;
        sel     = '0;
        res_src = '0;
        for (int k = 0; k < ISSUE; k++) begin
            for (int s = 0; s < NSRC; s++) begin
                src = id_src[(k*NSRC+s)*5 +: 5];
                sel = id_src_rf[(k*NSRC+s)*DW +: DW];
                for (int st = NSTAGE - 1; st >= 0; st--) begin
                    for (int l = 0; l < ISSUE; l++) begin
                        if (byp_we[st*ISSUE+l] && (byp_rd[(st*ISSUE+l)*5 +: 5] == src)) begin
                            sel = byp_data[(st*ISSUE+l)*DW +: DW];
                        end
                    end
                end
                if (src == 5'd0) begin
                    sel = '0;
                end
                res_src[(k*NSRC+s)*DW +: DW] = sel;
            end
        end
    end

    always_comb begin : hazards
        logic [4:0] rd_k;
        logic [4:0] rd_j;
        logic [4:0] src;
        rd_k   = '0;
        rd_j   = '0;
        src    = '0;
        hazard = '0;
        for (int k = 0; k < ISSUE; k++) begin
            rd_k = id_rd[k*5 +: 5];
            for (int s = 0; s < NSRC; s++) begin
                src = id_src[(k*NSRC+s)*5 +: 5];
                if ((src != 5'd0) && (cnt_q[src] != '0)) begin
                    hazard[k] = 1'b1;
                end
            end
            // An older write still in flight must not land after this one.
            if (id_we[k] && (rd_k != 5'd0) && (cnt_q[rd_k] > id_lat[k*LW +: LW])) begin
                hazard[k] = 1'b1;
            end
            for (int j = 0; j < k; j++) begin
                rd_j = id_rd[j*5 +: 5];
                if (id_we[j] && (rd_j != 5'd0)) begin
                    for (int s = 0; s < NSRC; s++) begin
                        if (id_src[(k*NSRC+s)*5 +: 5] == rd_j) begin
                            hazard[k] = 1'b1;
                        end
                    end
                    if (id_we[k] && (rd_k == rd_j)) begin
                        hazard[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : issue_gate
        logic prefix;
        prefix = 1'b1;
        accept = '0;
        for (int k = 0; k < ISSUE; k++) begin
            accept[k] = id_valid[k] & ~hazard[k] & prefix & ~flush;
            prefix    = accept[k];
        end
    end

    always_comb begin : scoreboard_next
        logic [4:0] rd_k;
        rd_k = '0;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
        end
        for (int k = 0; k < ISSUE; k++) begin
            rd_k = id_rd[k*5 +: 5];
            if (accept[k] && id_we[k] && (rd_k != 5'd0)) begin
                cnt_d[rd_k] = id_lat[k*LW +: LW];
            end
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt_d[r] = '0;
            end
        end
        cnt_d[0] = '0;
    end

    assign stall_d = stall_q + {31'd0, (id_valid[0] & ~accept[0] & ~flush)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            ex_valid_q <= '0;
            ex_we_q    <= '0;
            ex_rd_q    <= '0;
            ex_src_q   <= '0;
            stall_q    <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            ex_valid_q <= accept;
            ex_we_q    <= accept & id_we;
            ex_rd_q    <= id_rd;
            ex_src_q   <= res_src;
            stall_q    <= stall_d;
        end
    end

    assign id_accept = accept;
    assign ex_valid  = ex_valid_q;
    assign ex_we     = ex_we_q;
    assign ex_rd     = ex_rd_q;
    assign ex_src    = ex_src_q;
    assign stall_cnt = stall_q;

    // A latency beyond MAXLAT cannot be represented faithfully by the counters.
    for (genvar k = 0; k < ISSUE; k++) begin : g_lat_chk
        assert property (@(posedge clk) disable iff (rst)
            !(id_valid[k] && (id_lat[k*LW +: LW] > LW'(MAXLAT))));
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios then random bundles, checked
// against a ready-time register model kept in the bench.
module tb_fwd_scoreboard;

    localparam int ISSUE  = 2;
    localparam int NSRC   = 3;
    localparam int NSTAGE = 2;
    localparam int DW     = 32;
    localparam int MAXLAT = 4;
    localparam int LW     = 3;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic [ISSUE-1:0]           id_valid;
    logic [ISSUE*NSRC*5-1:0]    id_src;
    logic [ISSUE*NSRC*DW-1:0]   id_src_rf;
    logic [ISSUE*5-1:0]         id_rd;
    logic [ISSUE-1:0]           id_we;
    logic [ISSUE*LW-1:0]        id_lat;
    logic [NSTAGE*ISSUE-1:0]    byp_we;
    logic [NSTAGE*ISSUE*5-1:0]  byp_rd;
    logic [NSTAGE*ISSUE*DW-1:0] byp_data;
    logic [ISSUE-1:0]           id_accept;
    logic [ISSUE-1:0]           ex_valid;
    logic [ISSUE*NSRC*DW-1:0]   ex_src;
    logic [ISSUE*5-1:0]         ex_rd;
    logic [ISSUE-1:0]           ex_we;
    logic [31:0]                stall_cnt;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .ISSUE(ISSUE), .NSRC(NSRC), .NSTAGE(NSTAGE), .DW(DW), .MAXLAT(MAXLAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_src(id_src), .id_src_rf(id_src_rf),
        .id_rd(id_rd), .id_we(id_we), .id_lat(id_lat),
        .byp_we(byp_we), .byp_rd(byp_rd), .byp_data(byp_data),
        .id_accept(id_accept), .ex_valid(ex_valid), .ex_src(ex_src),
        .ex_rd(ex_rd), .ex_we(ex_we), .stall_cnt(stall_cnt)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    int              now_cyc  = 0;
    int              ready_at [32];
    logic [31:0]     m_stall;
    logic [DW-1:0]   exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        flush     = 1'b0;
        id_valid  = '0;
        id_src    = '0;
        id_src_rf = '0;
        id_rd     = '0;
        id_we     = '0;
        id_lat    = '0;
        byp_we    = '0;
        byp_rd    = '0;
        byp_data  = '0;
    endtask

    task automatic set_lane(input int k, input int v, input int we, input int rd, input int lat,
                            input int s0, input int s1, input int s2);
        id_valid[k]            = 1'(v);
        id_we[k]               = 1'(we);
        id_rd[k*5 +: 5]        = 5'(rd);
        id_lat[k*LW +: LW]     = LW'(lat);
        id_src[(k*NSRC+0)*5 +: 5] = 5'(s0);
        id_src[(k*NSRC+1)*5 +: 5] = 5'(s1);
        id_src[(k*NSRC+2)*5 +: 5] = 5'(s2);
    endtask

    task automatic set_rf(input int k, input int s, input logic [DW-1:0] d);
        id_src_rf[(k*NSRC+s)*DW +: DW] = d;
    endtask

    task automatic set_byp(input int st, input int l, input int we, input int rd, input logic [DW-1:0] d);
        byp_we[st*ISSUE+l]               = 1'(we);
        byp_rd[(st*ISSUE+l)*5 +: 5]      = 5'(rd);
        byp_data[(st*ISSUE+l)*DW +: DW]  = d;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] f_src(int k, int s);
        return id_src[(k*NSRC+s)*5 +: 5];
    endfunction

    function automatic logic [4:0] f_rd(int k);
        return id_rd[k*5 +: 5];
    endfunction

    function automatic int f_lat(int k);
        return int'(id_lat[k*LW +: LW]);
    endfunction

    // Cycles until register r can be read; a producer issued at cycle t with
    // latency L becomes readable at cycle t+1+L.
    function automatic int remaining(logic [4:0] r);
        if (r == 5'd0) return 0;
        return (ready_at[r] > now_cyc) ? ready_at[r] - now_cyc : 0;
    endfunction

    function automatic logic [ISSUE-1:0] model_accept();
        logic [ISSUE-1:0] a;
        bit               ok;
        bit               blocked;
        a  = '0;
        ok = 1'b1;
        if (flush) return '0;
        for (int k = 0; k < ISSUE; k++) begin
            blocked = !id_valid[k];
            for (int s = 0; s < NSRC; s++)
                if (remaining(f_src(k, s)) > 0) blocked = 1'b1;
            if (id_we[k] && f_rd(k) != 0 && remaining(f_rd(k)) > f_lat(k)) blocked = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (id_we[j] && f_rd(j) != 0) begin
                    for (int s = 0; s < NSRC; s++)
                        if (f_src(k, s) == f_rd(j)) blocked = 1'b1;
                    if (id_we[k] && f_rd(k) == f_rd(j)) blocked = 1'b1;
                end
            end
            ok   = ok && !blocked;
            a[k] = ok;
        end
        return a;
    endfunction

    function automatic logic [DW-1:0] model_resolve(int k, int s);
        logic [4:0] r;
        r = f_src(k, s);
        if (r == 5'd0) return '0;
        for (int st = 0; st < NSTAGE; st++)
            for (int l = ISSUE - 1; l >= 0; l--)
                if (byp_we[st*ISSUE+l] && byp_rd[(st*ISSUE+l)*5 +: 5] == r)
                    return byp_data[(st*ISSUE+l)*DW +: DW];
        return id_src_rf[(k*NSRC+s)*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        m_stall = '0;
        exp_q.delete();
    endtask

    // One clock with the currently driven inputs; checks accept before the
    // edge and the exe0 register contents after it.
    task automatic step(input string tag);
        logic [ISSUE-1:0] acc;
        logic [ISSUE-1:0] we_s;
        logic [4:0]       rds [ISSUE];
        #1;
        acc  = model_accept();
        we_s = id_we;
        check({tag, "/id_accept"}, 32'(id_accept), 32'(acc));
        for (int k = 0; k < ISSUE; k++) begin
            rds[k] = f_rd(k);
            if (acc[k])
                for (int s = 0; s < NSRC; s++) exp_q.push_back(model_resolve(k, s));
        end
        if (id_valid[0] && !acc[0] && !flush) m_stall = m_stall + 32'd1;
        if (flush) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
        end else begin
            for (int k = 0; k < ISSUE; k++)
                if (acc[k] && id_we[k] && f_rd(k) != 0) ready_at[f_rd(k)] = now_cyc + 1 + f_lat(k);
        end
        @(posedge clk);
        #1;
        now_cyc++;
        check({tag, "/ex_valid"}, 32'(ex_valid), 32'(acc));
        check({tag, "/ex_we"}, 32'(ex_we), 32'(acc & we_s));
        check({tag, "/stall_cnt"}, stall_cnt, m_stall);
        for (int k = 0; k < ISSUE; k++) begin
            if (acc[k]) begin
                check($sformatf("%s/ex_rd%0d", tag, k), 32'(ex_rd[k*5 +: 5]), 32'(rds[k]));
                for (int s = 0; s < NSRC; s++)
                    check($sformatf("%s/ex_src%0d_%0d", tag, k, s),
                          ex_src[(k*NSRC+s)*DW +: DW], exp_q.pop_front());
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/ex_valid"}, 32'(ex_valid), 32'd0);
        check({tag, "/ex_we"}, 32'(ex_we), 32'd0);
        check({tag, "/ex_rd"}, 32'(ex_rd), 32'd0);
        check({tag, "/stall_cnt"}, stall_cnt, 32'd0);
        for (int i = 0; i < ISSUE*NSRC; i++)
            check($sformatf("%s/ex_src%0d", tag, i), ex_src[i*DW +: DW], 32'd0);
    endtask

    int stall_base;

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        #1 rst = 1'b1;
        #1 check_reset_state("por");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // forwarding priority: youngest stage, highest lane wins
        clear_inputs();
        set_lane(0, 1, 0, 0, 0, 4, 0, 0);
        set_rf(0, 0, 32'hAAAA);
        set_byp(0, 1, 1, 4, 32'h22);
        set_byp(0, 0, 1, 4, 32'h11);
        set_byp(1, 0, 1, 4, 32'h33);
        step("fwd");
        check("fwd/prio_value", ex_src[DW-1:0], 32'h22);

        // load-use: ld r6 lat 2, dependent waits 2 cycles
        clear_inputs();
        set_lane(0, 1, 1, 6, 2, 1, 2, 0);
        step("lu_issue");
        stall_base = int'(m_stall);
        clear_inputs();
        set_lane(0, 1, 0, 0, 0, 6, 0, 0);
        set_rf(0, 0, 32'hDEAD);
        set_byp(0, 0, 1, 6, 32'h66);
        step("lu_wait1");
        check("lu_wait1/blocked", 32'(ex_valid), 32'd0);
        step("lu_wait2");
        check("lu_wait2/blocked", 32'(ex_valid), 32'd0);
        step("lu_go");
        check("lu_go/valid", 32'(ex_valid), 32'd1);
        check("lu_go/value", ex_src[DW-1:0], 32'h66);
        check("lu_go/stall_plus2", stall_cnt, 32'(stall_base + 2));

        // bundle split on intra-bundle RAW
        clear_inputs();
        set_lane(0, 1, 1, 3, 0, 1, 0, 0);
        set_lane(1, 1, 0, 0, 0, 3, 0, 0);
        step("split_bundle");
        check("split_bundle/acc01", 32'(ex_valid), 32'd1);
        clear_inputs();
        set_lane(1, 1, 0, 0, 0, 3, 0, 0);
        step("split_lane1_only");
        check("split_lane1_only/acc00", 32'(ex_valid), 32'd0);
        clear_inputs();
        set_lane(0, 1, 0, 0, 0, 3, 0, 0);
        step("split_lane0");
        check("split_lane0/acc01", 32'(ex_valid), 32'd1);

        // WAW: div r7 lat 3, ALU write r7 lat 0 waits; r0 source reads 0
        clear_inputs();
        set_lane(0, 1, 1, 7, 3, 1, 2, 0);
        step("waw_div");
        clear_inputs();
        set_lane(0, 1, 1, 7, 0, 0, 0, 0);
        set_byp(0, 0, 1, 0, 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            step("waw_wait");
            check("waw_wait/blocked", 32'(ex_valid), 32'd0);
        end
        step("waw_go");
        check("waw_go/valid", 32'(ex_valid), 32'd1);
        check("waw_go/r0_operand", ex_src[DW-1:0], 32'd0);

        // flush with r9 still busy
        clear_inputs();
        set_lane(0, 1, 1, 9, 3, 0, 0, 0);
        step("fl_issue");
        clear_inputs();
        step("fl_idle");
        stall_base = int'(m_stall);
        set_lane(0, 1, 0, 0, 0, 1, 0, 0);
        set_lane(1, 1, 0, 0, 0, 2, 0, 0);
        flush = 1'b1;
        step("fl_flush");
        check("fl_flush/ex_valid", 32'(ex_valid), 32'd0);
        check("fl_flush/stall_same", stall_cnt, 32'(stall_base));
        clear_inputs();
        set_lane(0, 1, 0, 0, 0, 9, 0, 0);
        step("fl_after");
        check("fl_after/r9_free", 32'(ex_valid), 32'd1);

        // asynchronous reset mid-run while r5 is busy
        clear_inputs();
        set_lane(0, 1, 1, 5, 3, 0, 0, 0);
        step("rst_issue");
        clear_inputs();
        #2 rst = 1'b1;
        #1 check_reset_state("mid_rst");
        model_reset();
        #2 rst = 1'b0;
        set_lane(0, 1, 0, 0, 0, 5, 0, 0);
        step("rst_after");
        check("rst_after/r5_free", 32'(ex_valid), 32'd1);

        // random bundles against the model
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            flush = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < ISSUE; k++) begin
                set_lane(k, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, MAXLAT)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)));
                for (int s = 0; s < NSRC; s++) set_rf(k, s, $urandom);
            end
            for (int st = 0; st < NSTAGE; st++)
                for (int l = 0; l < ISSUE; l++)
                    set_byp(st, l, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the dual-issue operand forwarding logic: combines an N-lane, N-stage bypass network with a per-register latency scoreboard and an in-order issue gate.
- Sits between decode/regfile read and the exe0 pipeline register.
- Resolves RAW via bypass, stalls on not-yet-ready producers (load-use, multi-cycle ops) and WAW, splits bundles on intra-bundle dependencies, and registers the selected operands into exe0.

Parameters:
ISSUE, 2, number of issue lanes (lane 0 oldest in program order)
NSRC, 3, source operands per lane (rj, rk, rd-as-source)
NSTAGE, 2, bypass stages (stage 0 = exe0/exe1, youngest)
DW, 32, datapath width
MAXLAT, 4, maximum producer latency in cycles; LW = clog2(MAXLAT+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  kill exe0 contents and clear scoreboard
id_valid  in  ISSUE  lane holds a decoded instruction
id_src  in  ISSUE*NSRC*5  source register indices
id_src_rf  in  ISSUE*NSRC*DW  regfile read data per source
id_rd  in  ISSUE*5  destination register
id_we  in  ISSUE  lane writes id_rd
id_lat  in  ISSUE*LW  cycles until result is on a ready bypass slot (0 = next cycle)
byp_we  in  NSTAGE*ISSUE  bypass slot writes a register
byp_rd  in  NSTAGE*ISSUE*5  bypass slot destination
byp_data  in  NSTAGE*ISSUE*DW  bypass slot result
id_accept  out  ISSUE  lanes issued this cycle (in-order prefix)
ex_valid  out  ISSUE  registered: exe0 lane valid
ex_src  out  ISSUE*NSRC*DW  registered: resolved operands
ex_rd  out  ISSUE*5  registered destination
ex_we  out  ISSUE  registered write enable
stall_cnt  out  32  cycles with id_valid[0]=1 and id_accept[0]=0

Behaviour:
- Reset (async, rst=1): ex_valid, ex_src, ex_rd, ex_we, stall_cnt = 0; all scoreboard counters = 0.
- Scoreboard: cnt[r], LW bits, r=1..31; r0 is never tracked (always 0).
- Each cycle, every nonzero cnt decrements by 1. An issuing lane with id_we=1 and id_rd!=0 loads cnt[id_rd]=id_lat instead; load wins over decrement.
- Bypass select per source (combinational): src==0 -> 0.
  - Otherwise search stage 0..NSTAGE-1; within a stage, lane ISSUE-1 down to 0. First slot with byp_we=1 and byp_rd==src wins.
  - If no slot matches, use id_src_rf.
  - Youngest-producer-wins ordering is mandatory.
- Lane k hazard (any of the following blocks the lane):
  - (a) any nonzero source s with cnt[s]!=0 (RAW not ready);
  - (b) id_we=1, id_rd!=0, cnt[id_rd] > id_lat (WAW; older write would land later);
  - (c) for some j<k with id_we[j]=1 and id_rd[j]!=0: any source of k == id_rd[j] (intra-bundle RAW) or id_rd[k]==id_rd[j] with id_we[k]=1 (intra-bundle WAW).
- id_accept[k] = id_valid[k] & ~hazard[k] & id_accept[k-1] (k>0) & ~flush. Lanes not accepted are re-presented by decode next cycle in the same lanes.
- exe0 register, updated every cycle: ex_valid[k] <= id_accept[k]. ex_src, ex_rd, ex_we load resolved values for accepted lanes. For non-accepted lanes ex_we is forced 0; other fields are don't-care.
- Latency: operand resolve to ex_src in 1 cycle; a producer with id_lat=L blocks dependents for exactly L cycles after its issue cycle.
- flush=1: next cycle ex_valid=0 and ex_we=0. All cnt cleared to 0 (overrides any load that cycle). id_accept=0. stall_cnt does not increment.
- stall_cnt wraps at 2^32-1 -> 0.
- id_lat > MAXLAT: illegal input; behaviour undefined, and an assertion must be provided.
- Mid-operation reset: all state cleared immediately, regardless of clk.

Test Plan:
- Reset with rst pulsed mid-run while cnt[5]=3 -> ex_valid=0, stall_cnt=0, cnt[5]=0; next issue reading r5 is accepted at once.
- Forward priority: stage0 lane1 byp r4=0x22, stage0 lane0 r4=0x11, stage1 lane0 r4=0x33; lane0 reads r4 -> ex_src=0x22.
- Load-use: lane0 issues ld r6 with id_lat=2; next cycle lane0 reads r6 -> id_accept=0 for 2 cycles, stall_cnt +2, then accepted with the bypassed value.
- Bundle split: lane0 writes r3 (lat 0), lane1 reads r3 -> id_accept=01. Next cycle lane1's instruction in lane1 with lane0 invalid -> id_accept stays 00 (prefix rule). Same instruction re-presented in lane0 -> accepted.
- WAW: r7 cnt=3 from a div, new ALU write r7 with id_lat=0 -> blocked until cnt[7]=0; src r0 with r0 bypass data 0xFFFF -> operand 0.
- flush while cnt[9]=2 and both lanes valid -> next cycle ex_valid=00, cnt[9]=0, stall_cnt unchanged.
